// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: byte-serial command/operand sequencer feeding an external 8-bit ALU and capturing its result
module alu_cmd_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic [3:0] out_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_sh_sel,
  input  logic [7:0] alu_y,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_v,
  output logic       busy
);
  typedef enum logic [2:0] {CMD, GET_A, GET_B, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [7:0] last_y;
  logic xfer;
  assign in_ready  = state == CMD || state == GET_A || state == GET_B;
  assign out_valid = state == RESP;
  assign busy      = state != CMD;
  assign xfer      = in_valid && in_ready;
  always_comb begin
    state_nx = state;
    case (state)
      CMD:     state_nx = xfer ? (in_data[4] ? GET_B : GET_A) : CMD;
      GET_A:   state_nx = xfer ? GET_B : GET_A;
      GET_B:   state_nx = xfer ? EXEC : GET_B;
      EXEC:    state_nx = cnt == 4'd0 ? RESP : EXEC;
      RESP:    state_nx = out_ready ? CMD : RESP;
      default: state_nx = CMD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CMD;
      cnt        <= '0;
      last_y     <= '0;
      out_y      <= '0;
      out_flags  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_sh_sel <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CMD && xfer) begin
        alu_op     <= in_data[2:0];
        alu_sh_sel <= in_data[3];
        if (in_data[4]) alu_a <= last_y;
      end
      if (state == GET_A && xfer) alu_a <= in_data;
      if (state == GET_B && xfer) begin
        alu_b <= in_data;
        cnt   <= 4'(EXEC_CYCLES - 1);
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          out_y     <= alu_y;
          out_flags <= {alu_c, alu_z, alu_n, alu_v};
          last_y    <= alu_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench for alu_cmd_sequencer with EXEC_CYCLES 1 and 4
module tb_alu_cmd_sequencer;
  logic clk = 0, rst = 1, sel = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, out_ready = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  function automatic logic [11:0] alu(input logic [7:0] a, b, input logic [2:0] op, input logic sh);
    logic [8:0] r;
    logic [7:0] y;
    logic c, v;
    c = 0; v = 0;
    if (!sh) begin
      case (op)
        3'd0: begin r = a + b; y = r[7:0]; c = r[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
        3'd4: begin r = {1'b0, a} - {1'b0, b}; y = r[7:0]; c = ~r[8]; v = (a[7] != b[7]) && (y[7] != a[7]); end
        3'd2: y = a & b;
        3'd3: y = a | b;
        default: y = a ^ b;
      endcase
    end else begin
      case (op)
        3'd1: begin y = a >> 1; c = a[0]; end
        3'd7: y = a;
        default: begin y = a << 1; c = a[7]; end
      endcase
    end
    return {c, y == 8'd0, y[7], v, y};
  endfunction
  logic [7:0] a1, b1, y1, a4, b4, y4, oy1, oy4;
  logic [2:0] op1, op4;
  logic sh1, sh4, c1, z1, n1, v1, c4, z4, n4, v4;
  logic ir1, ir4, ov1, ov4, bz1, bz4;
  logic [3:0] of1, of4;
  always_comb {c1, z1, n1, v1, y1} = alu(a1, b1, op1, sh1);
  always_comb {c4, z4, n4, v4, y4} = alu(a4, b4, op4, sh4);
  alu_cmd_sequencer #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && !sel), .in_ready(ir1),
    .out_valid(ov1), .out_ready(out_ready && !sel), .out_y(oy1), .out_flags(of1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_sh_sel(sh1),
    .alu_y(y1), .alu_c(c1), .alu_z(z1), .alu_n(n1), .alu_v(v1), .busy(bz1));
  alu_cmd_sequencer #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel), .in_ready(ir4),
    .out_valid(ov4), .out_ready(out_ready && sel), .out_y(oy4), .out_flags(of4),
    .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_sh_sel(sh4),
    .alu_y(y4), .alu_c(c4), .alu_z(z4), .alu_n(n4), .alu_v(v4), .busy(bz4));
  wire in_ready = sel ? ir4 : ir1;
  wire out_valid = sel ? ov4 : ov1;
  wire busy = sel ? bz4 : bz1;
  wire [7:0] out_y = sel ? oy4 : oy1;
  wire [3:0] out_flags = sel ? of4 : of1;
  wire [7:0] alu_a = sel ? a4 : a1;
  wire [7:0] alu_b = sel ? b4 : b1;
  wire [2:0] alu_op = sel ? op4 : op1;
  wire alu_sh_sel = sel ? sh4 : sh1;
  task automatic check(input string tag, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_out(input string tag, input int lat);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check(tag, n, lat);
  endtask
  task automatic recv;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("recv_ov", out_valid, 0);
    check("recv_ir", in_ready, 1);
  endtask
  initial begin
    #3;
    check("rst_ov", out_valid, 0);
    check("rst_y", out_y, 0);
    check("rst_fl", out_flags, 0);
    check("rst_a", alu_a, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    check("rst_ir", in_ready, 1);
    send(8'h00); send(8'h7F); send(8'h01);
    check("add_ov0", out_valid, 0);
    wait_out("add_lat", 1);
    check("add_y", out_y, 8'h80);
    check("add_fl", out_flags, 4'b0011);
    check("add_ir", in_ready, 0);
    check("add_busy", busy, 1);
    recv();
    send(8'h19);
    check("chn_a", alu_a, 8'h80);
    check("chn_op", {alu_op, alu_sh_sel}, {3'd1, 1'b1});
    check("chn_ir", in_ready, 1);
    send(8'h00);
    wait_out("chn_lat", 1);
    check("chn_y", out_y, 8'h40);
    check("chn_fl", out_flags, 4'b0000);
    recv();
    send(8'h04); send(8'h05); send(8'h05);
    wait_out("sub_lat", 1);
    check("sub_y", out_y, 8'h00);
    check("sub_fl", out_flags, 4'b1100);
    in_data = 8'hAA;
    in_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_ov", out_valid, 1);
      check("bp_ir", in_ready, 0);
      check("bp_y", {out_y, out_flags}, {8'h00, 4'b1100});
    end
    in_valid = 0;
    recv();
    check("bp_op", alu_op, 3'd4);
    check("bp_busy", busy, 0);
    send(8'h00); send(8'h12);
    check("mid_a", alu_a, 8'h12);
    @(negedge clk) rst = 1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_a_clr", alu_a, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    send(8'h1F);
    check("rc_a", alu_a, 8'h00);
    send(8'h55);
    check("rc_b", alu_b, 8'h55);
    wait_out("rc_lat", 1);
    check("rc_y", out_y, 8'h00);
    check("rc_fl", out_flags, 4'b0100);
    recv();
    sel = 1;
    #1;
    check("e4_ir", in_ready, 1);
    send(8'h02); send(8'hF0); send(8'h3C);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        check("e4_ab", {alu_a, alu_b}, {8'hF0, 8'h3C});
        @(posedge clk); #1; n++;
      end
      check("e4_lat", n, 4);
    end
    check("e4_y", out_y, 8'h30);
    check("e4_fl", out_flags, 4'b0000);
    check("e4_ab_resp", {alu_a, alu_b}, {8'hF0, 8'h3C});
    recv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

- Byte-serial command/operand sequencer that sits directly upstream of the 8-bit ALU and also captures what the ALU produces.
- Accepts a command byte and operand bytes over an 8-bit valid/ready input stream.
- Drives the ALU's A, B, op and sh_sel inputs from registers and waits a programmable settle time.
- Registers the ALU result and flags, then presents them on a valid/ready output stream; a chain mode reuses the previous result as operand A.

## Interface
- EXEC_CYCLES, 1: cycles the ALU inputs are held stable before the result is captured; legal range 1..15.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  command or operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- out_valid  out  1  out_y/out_flags valid
- out_ready  in  1  consumer accepts result
- out_y  out  8  registered ALU result
- out_flags  out  4  registered flags: [3]=C, [2]=Z, [1]=N, [0]=V
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_op  out  3  to ALU op
- alu_sh_sel  out  1  to ALU sh_sel
- alu_y  in  8  from ALU Y
- alu_c, alu_z, alu_n, alu_v  in  1 each  from ALU flags
- busy  out  1  high in any state other than CMD

## Operation
- Command byte fields:
  - [2:0] op, passed unchanged to the ALU.
  - [3] sh_sel.
  - [4] chain.
  - [7:5] reserved; ignored.
- FSM states: CMD, GET_A, GET_B, EXEC, RESP. Reset state is CMD.
- A byte transfers on a rising edge where in_valid && in_ready.
- CMD: in_ready=1.
  - On transfer, latch op and sh_sel into alu_op/alu_sh_sel.
  - chain=0 → GET_A.
  - chain=1 → alu_a <= last_y, then GET_B.
- GET_A: in_ready=1. On transfer, alu_a <= in_data, then GET_B.
- GET_B: in_ready=1. On transfer, alu_b <= in_data, load exec counter with EXEC_CYCLES-1, then EXEC.
- EXEC: in_ready=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: out_y <= alu_y, out_flags <= {alu_c,alu_z,alu_n,alu_v}, last_y <= alu_y, then RESP.
- RESP: in_ready=0, out_valid=1.
  - On out_valid && out_ready: → CMD.
  - out_y/out_flags keep their value until the next capture.
- last_y is an internal register cleared by reset; it is updated only on capture.
- in_ready and out_valid are decoded from state only, never from in_valid/out_ready; out_valid is never high together with in_ready.
- alu_a/alu_b/alu_op/alu_sh_sel change only on their load edges and are stable throughout EXEC and RESP.
- in_valid low in CMD/GET_A/GET_B: the state holds indefinitely.

## Timing
- Reset (asynchronous, immediate):
  - state=CMD.
  - in_ready=1 from the first cycle after rst deasserts.
  - out_valid=0, out_y=0, out_flags=0, alu_a=0, alu_b=0, alu_op=0, alu_sh_sel=0, last_y=0, busy=0.
- Latency: with the B byte accepted at edge k, the result is captured and out_valid rises at edge k+EXEC_CYCLES.
- Minimum transaction lengths:
  - chain=0: 3 input transfers + EXEC_CYCLES + 1 response cycle.
  - chain=1: one input cycle fewer.
- The first command byte after an output handshake can be accepted on the edge after that handshake.
- Reset asserted mid-operation (any state) aborts the transaction with no output. The next accepted byte is a command byte, and last_y=0.
- Chain after reset, or after an aborted transaction, uses A=last_y (0 after reset).
- Output held under backpressure: out_valid stays 1 and out_y/out_flags stay constant for as long as out_ready=0.

## Test plan
- Add: cmd 0x00, A 0x7F, B 0x01, EXEC_CYCLES=1 → out_y=0x80, out_flags=4'b0011, out_valid one cycle after B accept.
- Subtract: cmd 0x04, A 0x05, B 0x05 → out_y=0x00, out_flags=4'b1100.
- Chain: immediately after the add, cmd 0x19 (chain, sh_sel=1, logical right shift), B 0x00 → alu_a=0x80, no A byte consumed, out_y=0x40, out_flags=4'b0000.
- Backpressure: out_ready=0 for 5 cycles in RESP with in_valid=1 → out_valid=1, in_ready=0, out_y unchanged; no byte is consumed until after the handshake.
- Reset mid-op: rst pulse after the A byte, then cmd 0x1F (chain, pass S=A), B 0x55 → out_y=0x00, out_flags=4'b0100.
- EXEC_CYCLES=4: cmd 0x02, A 0xF0, B 0x3C → out_valid rises exactly 4 edges after B accept, out_y=0x30, out_flags=4'b0000; alu_a/alu_b stable throughout EXEC.
